// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT sequencer: transform size, modulus,
// coefficient width, transform mode and controller state encoding.
package ntt_pkg;

  localparam int LOG_N   = 8;
  localparam int N       = 1 << LOG_N;
  localparam int STAGE_W = $clog2(LOG_N);
  localparam int Q       = 8380417;
  localparam int DATA_W  = 23;

  typedef enum logic {
    NTT_FWD = 1'b0,
    NTT_INV = 1'b1
  } ntt_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } ntt_state_e;

endpackage

// File: rtl/ntt_ctrl_if.sv
// Command, RAM-address and butterfly-control bundle of the NTT sequencer.
// Optional cycle_cnt_o is present when NTT_CTRL_CYCLE_CNT_EN is defined.
interface ntt_ctrl_if;
  import ntt_pkg::*;

  logic             start_i;
  logic             inv_i;
  logic             busy_o;
  logic             done_o;
  logic [LOG_N-1:0] rd_addr_a_o;
  logic [LOG_N-1:0] rd_addr_b_o;
  logic [LOG_N-1:0] tw_idx_o;
  logic             sel_butterfly_o;
  logic             sel_red_o;
  logic             wr_en_o;
  logic [LOG_N-1:0] wr_addr_a_o;
  logic [LOG_N-1:0] wr_addr_b_o;
`ifdef NTT_CTRL_CYCLE_CNT_EN
  logic [15:0]      cycle_cnt_o;

  modport master (
    output start_i, inv_i,
    input  busy_o, done_o, rd_addr_a_o, rd_addr_b_o, tw_idx_o,
           sel_butterfly_o, sel_red_o, wr_en_o, wr_addr_a_o, wr_addr_b_o,
           cycle_cnt_o
  );

  modport slave (
    input  start_i, inv_i,
    output busy_o, done_o, rd_addr_a_o, rd_addr_b_o, tw_idx_o,
           sel_butterfly_o, sel_red_o, wr_en_o, wr_addr_a_o, wr_addr_b_o,
           cycle_cnt_o
  );
`else
  modport master (
    output start_i, inv_i,
    input  busy_o, done_o, rd_addr_a_o, rd_addr_b_o, tw_idx_o,
           sel_butterfly_o, sel_red_o, wr_en_o, wr_addr_a_o, wr_addr_b_o
  );

  modport slave (
    input  start_i, inv_i,
    output busy_o, done_o, rd_addr_a_o, rd_addr_b_o, tw_idx_o,
           sel_butterfly_o, sel_red_o, wr_en_o, wr_addr_a_o, wr_addr_b_o
  );
`endif

endinterface

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly address generator: maps (stage, issue index, mode)
// to the two coefficient addresses and the twiddle ROM index.
module ntt_addr_gen
  import ntt_pkg::*;
(
  input  logic [STAGE_W-1:0] stage,
  input  logic [LOG_N-2:0]   idx,
  input  ntt_mode_e          mode,
  output logic [LOG_N-1:0]   addr_a,
  output logic [LOG_N-1:0]   addr_b,
  output logic [LOG_N-1:0]   tw_idx
);

  logic [STAGE_W-1:0] sh;
  logic [LOG_N-1:0]   len;
  logic [LOG_N-1:0]   grp;
  logic [LOG_N-1:0]   ofs;
  logic [LOG_N-1:0]   base_tw;

  // len is a power of two, so group/offset split and g*2*len are pure shifts;
  // the inverse index relies on modulo-2^LOG_N wrap of 2^(s+1) when s=LOG_N-1.
  always_comb begin
    sh      = STAGE_W'(LOG_N - 1) - stage;
    len     = LOG_N'(1) << sh;
    grp     = {1'b0, idx} >> sh;
    ofs     = {1'b0, idx} & (len - LOG_N'(1));
    addr_a  = ((grp << sh) << 1) | ofs;
    addr_b  = addr_a + len;
    base_tw = LOG_N'(1) << stage;
    tw_idx  = (mode == NTT_INV) ? ((base_tw << 1) - LOG_N'(1) - grp)
                                : (base_tw + grp);
  end

endmodule

// File: rtl/ntt_ctrl.sv
// NTT/INTT butterfly sequencer: one issue per cycle, inter-stage drain, and a
// write-back delay line. NTT_CTRL_CYCLE_CNT_EN adds a busy-cycle counter.
module ntt_ctrl
  import ntt_pkg::*;
#(
  parameter int PIPE_LAT = 2
)
(
  input  logic     clk_i,
  input  logic     rst_i,
  ntt_ctrl_if.slave bus
);

  localparam int TW_D = (PIPE_LAT > 1) ? PIPE_LAT - 1 : 1;

  ntt_state_e         state;
  ntt_state_e         state_nxt;
  ntt_mode_e          mode;
  logic [LOG_N-2:0]   issue_cnt;
  logic [STAGE_W-1:0] stage_cnt;
  logic [STAGE_W-1:0] stage;
  logic [2:0]         drain_cnt;
  logic               accept;
  logic               issue;
  logic               last_issue;
  logic               last_stage;
  logic               drain_last;
  logic               red_now;

  logic [LOG_N-1:0]   gen_a, gen_b, gen_tw;
  logic [LOG_N-1:0]   hold_a, hold_b, hold_tw;
  logic [LOG_N-1:0]   cur_a, cur_b, cur_tw;

  logic               vld_pipe [PIPE_LAT];
  logic [LOG_N-1:0]   a_pipe   [PIPE_LAT];
  logic [LOG_N-1:0]   b_pipe   [PIPE_LAT];
  logic [LOG_N-1:0]   tw_pipe  [TW_D];
  logic               red_pipe [TW_D];

  assign accept     = (state == IDLE) && bus.start_i;
  assign issue      = (state == RUN);
  assign last_issue = &issue_cnt;
  assign last_stage = (stage_cnt == STAGE_W'(LOG_N - 1));
  assign drain_last = (drain_cnt == 3'(PIPE_LAT - 1));
  assign stage      = (mode == NTT_INV) ? STAGE_W'(LOG_N - 1) - stage_cnt : stage_cnt;
  // The final INTT stage (s=0) carries the n^-1 scaling.
  assign red_now    = issue && (mode == NTT_INV) && last_stage;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start_i) state_nxt = RUN;
      RUN:     if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (drain_last) state_nxt = last_stage ? DONE : RUN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode      <= NTT_FWD;
      issue_cnt <= '0;
      stage_cnt <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          mode      <= ntt_mode_e'(bus.inv_i);
          issue_cnt <= '0;
          stage_cnt <= '0;
          drain_cnt <= '0;
        end
        RUN: begin
          issue_cnt <= issue_cnt + (LOG_N-1)'(1);
          drain_cnt <= '0;
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 3'd1;
          if (drain_last) begin
            issue_cnt <= '0;
            if (!last_stage) stage_cnt <= stage_cnt + STAGE_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  ntt_addr_gen u_addr_gen (
    .stage  (stage),
    .idx    (issue_cnt),
    .mode   (mode),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw_idx (gen_tw)
  );

  // Outside RUN the address and twiddle outputs freeze at the last issue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_a  <= '0;
      hold_b  <= '0;
      hold_tw <= '0;
    end else if (issue) begin
      hold_a  <= gen_a;
      hold_b  <= gen_b;
      hold_tw <= gen_tw;
    end
  end

  assign cur_a  = issue ? gen_a  : hold_a;
  assign cur_b  = issue ? gen_b  : hold_b;
  assign cur_tw = issue ? gen_tw : hold_tw;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < PIPE_LAT; k++) begin
        vld_pipe[k] <= 1'b0;
        a_pipe[k]   <= '0;
        b_pipe[k]   <= '0;
      end
      for (int k = 0; k < TW_D; k++) begin
        tw_pipe[k]  <= '0;
        red_pipe[k] <= 1'b0;
      end
    end else begin
      vld_pipe[0] <= issue;
      a_pipe[0]   <= cur_a;
      b_pipe[0]   <= cur_b;
      tw_pipe[0]  <= cur_tw;
      red_pipe[0] <= red_now;
      for (int k = 1; k < PIPE_LAT; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        a_pipe[k]   <= a_pipe[k-1];
        b_pipe[k]   <= b_pipe[k-1];
      end
      for (int k = 1; k < TW_D; k++) begin
        tw_pipe[k]  <= tw_pipe[k-1];
        red_pipe[k] <= red_pipe[k-1];
      end
    end
  end

  // Twiddle and reduction select meet the RAM data one cycle before write-back.
  if (PIPE_LAT == 1) begin : g_tw_direct
    assign bus.tw_idx_o  = cur_tw;
    assign bus.sel_red_o = red_now;
  end else begin : g_tw_delayed
    assign bus.tw_idx_o  = tw_pipe[PIPE_LAT-2];
    assign bus.sel_red_o = red_pipe[PIPE_LAT-2];
  end

  assign bus.busy_o          = (state == RUN) || (state == DRAIN);
  assign bus.done_o          = (state == DONE);
  assign bus.rd_addr_a_o     = cur_a;
  assign bus.rd_addr_b_o     = cur_b;
  assign bus.sel_butterfly_o = mode;
  assign bus.wr_en_o         = vld_pipe[PIPE_LAT-1];
  assign bus.wr_addr_a_o     = a_pipe[PIPE_LAT-1];
  assign bus.wr_addr_b_o     = b_pipe[PIPE_LAT-1];

`ifdef NTT_CTRL_CYCLE_CNT_EN
  logic [15:0] cycle_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i)                cycle_cnt <= '0;
    else if (accept)          cycle_cnt <= '0;
    else if (bus.busy_o)      cycle_cnt <= cycle_cnt + 16'd1;
  end

  assign bus.cycle_cnt_o = cycle_cnt;
`endif

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed bench for ntt_ctrl (N=256, PIPE_LAT=2): vector table plus a
// spec-timing model sweep, start-glitch, and reset-abort sequences.
module tb_ntt_ctrl;
  import ntt_pkg::*;

  localparam int LAST_C = 1045;

  typedef enum {K_RD, K_TW, K_WR, K_SB, K_DN, K_BZ, K_RED} kind_e;

  typedef struct {
    logic  inv;
    int    cyc;
    kind_e kind;
    int    v0;
    int    v1;
    int    v2;
  } vec_t;

  typedef struct {
    int rd_a, rd_b, tw, wr_en, wa, wb, sb, red, done, busy;
  } snap_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  vec_t  vecs[$];
  snap_t snap [0:LAST_C];
  int    ea [0:LAST_C];
  int    eb [0:LAST_C];
  int    etw[0:LAST_C];
  int    ev [0:LAST_C];
  int    er [0:LAST_C];
  bit    written [0:7][0:255];
  int    last_cnt;

  ntt_ctrl_if bus ();

  ntt_ctrl #(.PIPE_LAT(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add_vec(input logic inv, input int cyc, input kind_e kind,
                                  input int v0, input int v1, input int v2);
    vec_t v;
    v.inv = inv; v.cyc = cyc; v.kind = kind; v.v0 = v0; v.v1 = v1; v.v2 = v2;
    vecs.push_back(v);
  endfunction

  function automatic snap_t sample();
    snap_t s;
    s.rd_a = int'(bus.rd_addr_a_o); s.rd_b = int'(bus.rd_addr_b_o);
    s.tw   = int'(bus.tw_idx_o);    s.wr_en = int'(bus.wr_en_o);
    s.wa   = int'(bus.wr_addr_a_o); s.wb   = int'(bus.wr_addr_b_o);
    s.sb   = int'(bus.sel_butterfly_o); s.red = int'(bus.sel_red_o);
    s.done = int'(bus.done_o);      s.busy = int'(bus.busy_o);
    return s;
  endfunction

  // Cycle 0 is the cycle in which start is seen; snap[c] holds cycle c outputs.
  task automatic apply_stimulus(input logic inv_v, input int glitch_c);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.inv_i   = inv_v;
    for (int c = 1; c <= LAST_C; c++) begin
      @(negedge clk);
      snap[c] = sample();
      bus.start_i = (c == glitch_c);
      bus.inv_i   = (glitch_c > 0 && c >= glitch_c) ? ~inv_v : inv_v;
    end
`ifdef NTT_CTRL_CYCLE_CNT_EN
    last_cnt = int'(bus.cycle_cnt_o);
`else
    last_cnt = 0;
`endif
    bus.inv_i = 1'b0;
  endtask

  task automatic build_model(input logic inv_v);
    int k, off, s, len, g, j;
    for (int c = 1; c <= LAST_C; c++) begin
      k   = (c - 1) / 130;
      off = (c - 1) % 130;
      if (k < 8 && off < 128) begin
        s   = inv_v ? 7 - k : k;
        len = 256 >> (s + 1);
        g   = off / len;
        j   = off % len;
        ea[c]  = g * 2 * len + j;
        eb[c]  = ea[c] + len;
        etw[c] = inv_v ? (2 << s) - 1 - g : (1 << s) + g;
        ev[c]  = 1;
        er[c]  = (inv_v && s == 0) ? 1 : 0;
      end else begin
        ea[c] = ea[c-1]; eb[c] = eb[c-1]; etw[c] = etw[c-1];
        ev[c] = 0; er[c] = 0;
      end
    end
  endtask

  task automatic check_output(input logic inv_v, input string tag);
    int mm, wr_cnt, done_cnt, dup, st;
    snap_t s;
    build_model(inv_v);
    mm = 0; wr_cnt = 0; done_cnt = 0; dup = 0;
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 256; b++) written[a][b] = 1'b0;
    for (int c = 1; c <= LAST_C; c++) begin
      s = snap[c];
      if (s.rd_a != ea[c] || s.rd_b != eb[c]) mm++;
      if (s.sb != int'(inv_v)) mm++;
      if (s.busy != int'(c <= 1040)) mm++;
      if (c >= 2 && (s.tw != etw[c-1] || s.red != er[c-1])) mm++;
      if (c >= 3 && (s.wr_en != ev[c-2] || s.wa != ea[c-2] || s.wb != eb[c-2])) mm++;
      if (s.done == 1) done_cnt++;
      if (s.wr_en == 1) begin
        wr_cnt++;
        st = (c - 3) / 130;
        if (st < 8) begin
          if (written[st][s.wa] || written[st][s.wb]) dup++;
          written[st][s.wa] = 1'b1;
          written[st][s.wb] = 1'b1;
        end
      end
    end
    check({tag, " model_sweep"}, mm, 0);
    check({tag, " wr_pulses"}, wr_cnt, 1024);
    check({tag, " done_pulses"}, done_cnt, 1);
    check({tag, " dup_writes"}, dup, 0);
`ifdef NTT_CTRL_CYCLE_CNT_EN
    check({tag, " cycle_cnt"}, last_cnt, 1040);
`endif
    foreach (vecs[n]) begin
      if (vecs[n].inv == inv_v) begin
        s = snap[vecs[n].cyc];
        case (vecs[n].kind)
          K_RD: begin
            check($sformatf("%s rd_a@%0d", tag, vecs[n].cyc), s.rd_a, vecs[n].v0);
            check($sformatf("%s rd_b@%0d", tag, vecs[n].cyc), s.rd_b, vecs[n].v1);
          end
          K_TW:  check($sformatf("%s tw@%0d", tag, vecs[n].cyc), s.tw, vecs[n].v0);
          K_WR: begin
            check($sformatf("%s wr_en@%0d", tag, vecs[n].cyc), s.wr_en, vecs[n].v0);
            check($sformatf("%s wr_a@%0d", tag, vecs[n].cyc), s.wa, vecs[n].v1);
            check($sformatf("%s wr_b@%0d", tag, vecs[n].cyc), s.wb, vecs[n].v2);
          end
          K_SB:  check($sformatf("%s sel_bf@%0d", tag, vecs[n].cyc), s.sb, vecs[n].v0);
          K_DN:  check($sformatf("%s done@%0d", tag, vecs[n].cyc), s.done, vecs[n].v0);
          K_BZ:  check($sformatf("%s busy@%0d", tag, vecs[n].cyc), s.busy, vecs[n].v0);
          K_RED: check($sformatf("%s sel_red@%0d", tag, vecs[n].cyc), s.red, vecs[n].v0);
          default: ;
        endcase
      end
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'(bus.busy_o) | 32'(bus.done_o) | 32'(bus.rd_addr_a_o) | 32'(bus.rd_addr_b_o)
         | 32'(bus.tw_idx_o) | 32'(bus.sel_butterfly_o) | 32'(bus.sel_red_o)
         | 32'(bus.wr_en_o) | 32'(bus.wr_addr_a_o) | 32'(bus.wr_addr_b_o);
  endfunction

  initial begin
    int bad;
    checks = 0;
    errors = 0;

    // Twiddle index appears one cycle after its issue cycle.
    add_vec(0,    1, K_RD,  0, 128, 0);
    add_vec(0,    2, K_TW,  1, 0, 0);
    add_vec(0,    1, K_SB,  0, 0, 0);
    add_vec(0,    2, K_RD,  1, 129, 0);
    add_vec(0,    3, K_WR,  1, 0, 128);
    add_vec(0,  129, K_RD,  127, 255, 0);
    add_vec(0,  131, K_RD,  0, 64, 0);
    add_vec(0,  132, K_TW,  2, 0, 0);
    add_vec(0,  195, K_RD,  128, 192, 0);
    add_vec(0,  196, K_TW,  3, 0, 0);
    add_vec(0,  911, K_RD,  0, 1, 0);
    add_vec(0,  912, K_TW,  128, 0, 0);
    add_vec(0, 1000, K_RED, 0, 0, 0);
    add_vec(0, 1040, K_WR,  1, 254, 255);
    add_vec(0, 1041, K_WR,  0, 254, 255);
    add_vec(0, 1040, K_DN,  0, 0, 0);
    add_vec(0, 1041, K_DN,  1, 0, 0);
    add_vec(0, 1042, K_DN,  0, 0, 0);
    add_vec(0, 1040, K_BZ,  1, 0, 0);
    add_vec(0, 1041, K_BZ,  0, 0, 0);
    add_vec(1,    1, K_RD,  0, 1, 0);
    add_vec(1,    2, K_TW,  255, 0, 0);
    add_vec(1,    1, K_SB,  1, 0, 0);
    add_vec(1,    2, K_RD,  2, 3, 0);
    add_vec(1,    3, K_TW,  254, 0, 0);
    add_vec(1,  911, K_RD,  0, 128, 0);
    add_vec(1,  912, K_TW,  1, 0, 0);
    add_vec(1,  911, K_RED, 0, 0, 0);
    add_vec(1,  912, K_RED, 1, 0, 0);
    add_vec(1, 1039, K_RED, 1, 0, 0);
    add_vec(1, 1040, K_RED, 0, 0, 0);
    add_vec(1, 1041, K_DN,  1, 0, 0);

    rst = 1'b1;
    bus.start_i = 1'b0;
    bus.inv_i   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    rst = 1'b0;

    $display("[TB] forward run with start/inv glitch at cycle 500");
    apply_stimulus(1'b0, 500);
    check_output(1'b0, "fwd_glitch");

    $display("[TB] reset abort at cycle 300");
    @(negedge clk);
    bus.start_i = 1'b1;
    for (int c = 1; c <= 301; c++) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      rst = (c == 300);
    end
    check("abort_outputs", all_outputs(), 0);
    bad = 0;
    for (int c = 302; c <= 340; c++) begin
      @(negedge clk);
      if (bus.wr_en_o || bus.done_o || bus.busy_o) bad++;
    end
    check("abort_quiet", bad, 0);

    $display("[TB] forward run after abort");
    apply_stimulus(1'b0, 0);
    check_output(1'b0, "fwd");

    $display("[TB] inverse run");
    apply_stimulus(1'b1, 0);
    check_output(1'b1, "inv");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
